ex_mem_responder: RTL and testbench

- Responder side of the execute-to-memory interface. Accepts one resolved instruction per handshake from the execute stage: ALU result, store data, branch target, zero flag and control bits.
- Resolves branches and returns a one-cycle PC redirect to fetch.
- Runs load/store transactions on a req/ack data-memory port.
- Emits a single-cycle write-back packet for the register file.

---
 rtl/ex_mem_responder_if.sv | 53 +++++
 rtl/ex_mem_responder.sv | 129 ++++++++++++
 tb/tb_ex_mem_responder.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mem_responder_if.sv
// Execute-to-memory bundle: execute handshake, data-memory port, branch redirect
// and write-back packet. slave = responder side, master = surrounding pipeline.
interface ex_mem_responder_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RD_W   = 5
) ();
    logic              ex_valid;
    logic              ex_ready;
    logic [RD_W-1:0]   ex_rd;
    logic [DATA_W-1:0] ex_result;
    logic [DATA_W-1:0] ex_store_data;
    logic [DATA_W-1:0] ex_branch_addr;
    logic              ex_zero;
    logic              ex_b;
    logic              ex_bz;
    logic              ex_bnz;
    logic              ex_mem_read;
    logic              ex_mem_write;
    logic              ex_mem_to_reg;
    logic              ex_reg_write;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    logic              pc_src;
    logic [DATA_W-1:0] branch_target;

    logic              wb_valid;
    logic              wb_reg_write;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              mem_err;

    modport slave (
        input  ex_valid, ex_rd, ex_result, ex_store_data, ex_branch_addr, ex_zero,
               ex_b, ex_bz, ex_bnz, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_reg_write, dmem_ack, dmem_rdata,
        output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc_src,
               branch_target, wb_valid, wb_reg_write, wb_rd, wb_data, mem_err
    );

    modport master (
        output ex_valid, ex_rd, ex_result, ex_store_data, ex_branch_addr, ex_zero,
               ex_b, ex_bz, ex_bnz, ex_mem_read, ex_mem_write, ex_mem_to_reg,
               ex_reg_write, dmem_ack, dmem_rdata,
        input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata, pc_src,
               branch_target, wb_valid, wb_reg_write, wb_rd, wb_data, mem_err
    );
endinterface

// File: rtl/ex_mem_responder.sv
// Responder for the execute-to-memory stage: resolves branches, runs load/store
// on a req/ack data port and emits a one-cycle write-back packet.
// Optional macro MEM_TIMEOUT_EN: abort an access after TIMEOUT cycles without ack.
module ex_mem_responder #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    ex_mem_responder_if.slave bus
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t          state;
    logic [RD_W-1:0] acc_rd;
    logic            acc_mem_to_reg;
    logic            acc_reg_write;
    logic            taken;
    logic            rw_conflict;
    logic            mem_op;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0] wait_cnt;
`else
    logic unused_timeout;
    assign unused_timeout = ^32'(TIMEOUT);
`endif

    // Branch decision and memory-op classification of the offered instruction
    always_comb begin
        taken       = bus.ex_b | (bus.ex_bz & bus.ex_zero) | (bus.ex_bnz & ~bus.ex_zero);
        rw_conflict = bus.ex_mem_read & bus.ex_mem_write;
        mem_op      = bus.ex_mem_read | bus.ex_mem_write;
    end

    // Accept/access FSM with all outputs registered; strobes default low each cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state              <= IDLE;
            bus.ex_ready       <= 1'b1;
            bus.dmem_req       <= 1'b0;
            bus.dmem_we        <= 1'b0;
            bus.dmem_addr      <= '0;
            bus.dmem_wdata     <= '0;
            bus.pc_src         <= 1'b0;
            bus.branch_target  <= '0;
            bus.wb_valid       <= 1'b0;
            bus.wb_reg_write   <= 1'b0;
            bus.wb_rd          <= '0;
            bus.wb_data        <= '0;
            bus.mem_err        <= 1'b0;
            acc_rd             <= '0;
            acc_mem_to_reg     <= 1'b0;
            acc_reg_write      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt           <= '0;
`endif
        end else begin
            bus.pc_src   <= 1'b0;
            bus.wb_valid <= 1'b0;
            bus.mem_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.ex_valid && bus.ex_ready) begin
                        if (taken) begin
                            bus.pc_src        <= 1'b1;
                            bus.branch_target <= bus.ex_branch_addr;
                        end
                        if (rw_conflict) begin
                            // Illegal read+write: flag it and retire without memory
                            bus.mem_err      <= 1'b1;
                            bus.wb_valid     <= 1'b1;
                            bus.wb_reg_write <= 1'b0;
                            bus.wb_rd        <= bus.ex_rd;
                            bus.wb_data      <= bus.ex_result;
                        end else if (mem_op) begin
                            state          <= ACCESS;
                            bus.ex_ready   <= 1'b0;
                            bus.dmem_req   <= 1'b1;
                            bus.dmem_we    <= bus.ex_mem_write;
                            bus.dmem_addr  <= bus.ex_result;
                            bus.dmem_wdata <= bus.ex_store_data;
                            acc_rd         <= bus.ex_rd;
                            acc_mem_to_reg <= bus.ex_mem_to_reg;
                            acc_reg_write  <= bus.ex_reg_write;
`ifdef MEM_TIMEOUT_EN
                            wait_cnt       <= '0;
`endif
                        end else begin
                            bus.wb_valid     <= 1'b1;
                            bus.wb_reg_write <= bus.ex_reg_write;
                            bus.wb_rd        <= bus.ex_rd;
                            bus.wb_data      <= bus.ex_result;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.dmem_ack && bus.dmem_req) begin
                        // Ack wins over a coincident timeout
                        state            <= IDLE;
                        bus.ex_ready     <= 1'b1;
                        bus.dmem_req     <= 1'b0;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_rd        <= acc_rd;
                        bus.wb_reg_write <= bus.dmem_we ? 1'b0 : acc_reg_write;
                        bus.wb_data      <= (!bus.dmem_we && acc_mem_to_reg) ? bus.dmem_rdata
                                                                             : bus.dmem_addr;
`ifdef MEM_TIMEOUT_EN
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state            <= IDLE;
                        bus.ex_ready     <= 1'b1;
                        bus.dmem_req     <= 1'b0;
                        bus.mem_err      <= 1'b1;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_reg_write <= 1'b0;
                        bus.wb_rd        <= acc_rd;
                        bus.wb_data      <= bus.dmem_addr;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mem_responder.sv
// Directed bench for ex_mem_responder with a write-back scoreboard.
module tb_ex_mem_responder;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned RD_W   = 5;

    typedef struct {
        logic        reg_write;
        logic [4:0]  rd;
        logic [63:0] data;
        logic        err;
        logic        chk_data;
    } wb_exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    wb_exp_t sb[$];

    ex_mem_responder_if #(.DATA_W(DATA_W), .RD_W(RD_W)) bus ();

    ex_mem_responder #(.DATA_W(DATA_W), .RD_W(RD_W), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.ex_valid       = 1'b0;
        bus.ex_rd          = '0;
        bus.ex_result      = '0;
        bus.ex_store_data  = '0;
        bus.ex_branch_addr = '0;
        bus.ex_zero        = 1'b0;
        bus.ex_b           = 1'b0;
        bus.ex_bz          = 1'b0;
        bus.ex_bnz         = 1'b0;
        bus.ex_mem_read    = 1'b0;
        bus.ex_mem_write   = 1'b0;
        bus.ex_mem_to_reg  = 1'b0;
        bus.ex_reg_write   = 1'b0;
    endtask

    task automatic push(input logic rw, input logic [4:0] rd, input logic [63:0] d,
                        input logic err, input logic chk);
        wb_exp_t e;
        e.reg_write = rw;
        e.rd        = rd;
        e.data      = d;
        e.err       = err;
        e.chk_data  = chk;
        sb.push_back(e);
    endtask

    // Write-back monitor: every wb_valid strobe must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && bus.wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 64'(bus.wb_valid), 64'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_reg_write", 64'(bus.wb_reg_write), 64'(e.reg_write));
                check("wb_rd", 64'(bus.wb_rd), 64'(e.rd));
                if (e.chk_data) check("wb_data", bus.wb_data, e.data);
                check("wb_mem_err", 64'(bus.mem_err), 64'(e.err));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        clear_in();
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = '0;
        tick();
        tick();
        // Reset state
        check("rst_ex_ready", 64'(bus.ex_ready), 64'd1);
        check("rst_dmem_req", 64'(bus.dmem_req), 64'd0);
        check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        check("rst_pc_src", 64'(bus.pc_src), 64'd0);
        check("rst_mem_err", 64'(bus.mem_err), 64'd0);
        check("rst_wb_data", bus.wb_data, 64'd0);
        check("rst_dmem_addr", bus.dmem_addr, 64'd0);
        check("rst_branch_target", bus.branch_target, 64'd0);
        reset = 1'b0;
        tick();

        // Back-to-back ALU ops
        bus.ex_valid = 1'b1; bus.ex_result = 64'h2A; bus.ex_rd = 5'd3; bus.ex_reg_write = 1'b1;
        push(1'b1, 5'd3, 64'h2A, 1'b0, 1'b1);
        tick();
        check("alu1_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("alu1_ex_ready", 64'(bus.ex_ready), 64'd1);
        bus.ex_result = 64'h1234; bus.ex_rd = 5'd9;
        push(1'b1, 5'd9, 64'h1234, 1'b0, 1'b1);
        tick();
        check("alu2_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("alu2_ex_ready", 64'(bus.ex_ready), 64'd1);
        clear_in();
        tick();
        check("alu_wb_drop", 64'(bus.wb_valid), 64'd0);

        // BZ taken
        bus.ex_valid = 1'b1; bus.ex_bz = 1'b1; bus.ex_zero = 1'b1; bus.ex_branch_addr = 64'h1000;
        push(1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
        tick();
        clear_in();
        check("bz_taken_pc_src", 64'(bus.pc_src), 64'd1);
        check("bz_taken_target", bus.branch_target, 64'h1000);
        tick();
        check("bz_pulse_one_cycle", 64'(bus.pc_src), 64'd0);
        // BZ not taken
        bus.ex_valid = 1'b1; bus.ex_bz = 1'b1; bus.ex_zero = 1'b0; bus.ex_branch_addr = 64'h2000;
        push(1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
        tick();
        clear_in();
        check("bz_not_taken", 64'(bus.pc_src), 64'd0);
        tick();
        // Unconditional B with zero low
        bus.ex_valid = 1'b1; bus.ex_b = 1'b1; bus.ex_branch_addr = 64'h3000;
        push(1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
        tick();
        check("b_taken_pc_src", 64'(bus.pc_src), 64'd1);
        check("b_taken_target", bus.branch_target, 64'h3000);
        // BNZ with zero low, issued back to back
        bus.ex_b = 1'b0; bus.ex_bnz = 1'b1; bus.ex_branch_addr = 64'h4000;
        push(1'b0, 5'd0, 64'd0, 1'b0, 1'b1);
        tick();
        clear_in();
        check("bnz_taken_pc_src", 64'(bus.pc_src), 64'd1);
        check("bnz_taken_target", bus.branch_target, 64'h4000);
        tick();

        // Load with ack after three request cycles
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_to_reg = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd7; bus.ex_result = 64'h80;
        push(1'b1, 5'd7, 64'hDEADBEEF, 1'b0, 1'b1);
        tick();
        clear_in();
        check("ld_req_c1", 64'(bus.dmem_req), 64'd1);
        check("ld_we", 64'(bus.dmem_we), 64'd0);
        check("ld_addr", bus.dmem_addr, 64'h80);
        check("ld_ready_c1", 64'(bus.ex_ready), 64'd0);
        tick();
        check("ld_ready_c2", 64'(bus.ex_ready), 64'd0);
        check("ld_wb_c2", 64'(bus.wb_valid), 64'd0);
        tick();
        check("ld_ready_c3", 64'(bus.ex_ready), 64'd0);
        check("ld_req_c3", 64'(bus.dmem_req), 64'd1);
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hDEADBEEF;
        tick();
        bus.dmem_ack = 1'b0;
        check("ld_done_req", 64'(bus.dmem_req), 64'd0);
        check("ld_done_ready", 64'(bus.ex_ready), 64'd1);
        check("ld_done_wb_valid", 64'(bus.wb_valid), 64'd1);
        tick();

        // Load with ack already high: wb two cycles after accept; idle ack ignored
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_to_reg = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd8; bus.ex_result = 64'h90;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h77;
        push(1'b1, 5'd8, 64'h77, 1'b0, 1'b1);
        tick();
        clear_in();
        check("ldfast_wb_c1", 64'(bus.wb_valid), 64'd0);
        check("ldfast_req_c1", 64'(bus.dmem_req), 64'd1);
        tick();
        check("ldfast_wb_c2", 64'(bus.wb_valid), 64'd1);
        check("ldfast_req_c2", 64'(bus.dmem_req), 64'd0);
        tick();
        check("idle_ack_ignored_wb", 64'(bus.wb_valid), 64'd0);
        check("idle_ack_ignored_req", 64'(bus.dmem_req), 64'd0);
        // Load without mem_to_reg returns the ALU result
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1;
        bus.ex_rd = 5'd2; bus.ex_result = 64'hA0; bus.dmem_rdata = 64'hFF;
        push(1'b1, 5'd2, 64'hA0, 1'b0, 1'b1);
        tick();
        clear_in();
        tick();
        bus.dmem_ack = 1'b0;
        tick();

        // Store: write enable, data and suppressed register write
        bus.ex_valid = 1'b1; bus.ex_mem_write = 1'b1; bus.ex_reg_write = 1'b1;
        bus.ex_rd = 5'd4; bus.ex_result = 64'h10; bus.ex_store_data = 64'h55;
        push(1'b0, 5'd4, 64'h10, 1'b0, 1'b1);
        tick();
        clear_in();
        check("st_we", 64'(bus.dmem_we), 64'd1);
        check("st_wdata", bus.dmem_wdata, 64'h55);
        check("st_addr", bus.dmem_addr, 64'h10);
        bus.dmem_ack = 1'b1;
        tick();
        bus.dmem_ack = 1'b0;
        check("st_done_wb", 64'(bus.wb_valid), 64'd1);
        tick();

        // Read+write conflict
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_write = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd6; bus.ex_result = 64'h33;
        push(1'b0, 5'd6, 64'h33, 1'b1, 1'b1);
        tick();
        clear_in();
        check("conf_mem_err", 64'(bus.mem_err), 64'd1);
        check("conf_no_req", 64'(bus.dmem_req), 64'd0);
        check("conf_ready", 64'(bus.ex_ready), 64'd1);
        tick();
        check("conf_err_once", 64'(bus.mem_err), 64'd0);
        check("conf_no_req_c2", 64'(bus.dmem_req), 64'd0);

`ifdef MEM_TIMEOUT_EN
        // Timeout after four unacknowledged request cycles
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_mem_to_reg = 1'b1;
        bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd11; bus.ex_result = 64'h200;
        push(1'b0, 5'd11, 64'd0, 1'b1, 1'b0);
        tick();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            check("to_req_held", 64'(bus.dmem_req), 64'd1);
            if (i < 3) tick();
        end
        tick();
        check("to_req_drop", 64'(bus.dmem_req), 64'd0);
        check("to_mem_err", 64'(bus.mem_err), 64'd1);
        check("to_wb_valid", 64'(bus.wb_valid), 64'd1);
        check("to_ready", 64'(bus.ex_ready), 64'd1);
        tick();
`endif

        // Reset asserted mid-access abandons the transaction
        bus.ex_valid = 1'b1; bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1;
        bus.ex_rd = 5'd12; bus.ex_result = 64'h300;
        tick();
        clear_in();
        check("mid_req_before_rst", 64'(bus.dmem_req), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 64'(bus.dmem_req), 64'd0);
        check("mid_rst_ready", 64'(bus.ex_ready), 64'd1);
        check("mid_rst_wb", 64'(bus.wb_valid), 64'd0);
        check("mid_rst_pc_src", 64'(bus.pc_src), 64'd0);
        tick();
        reset = 1'b0;
        bus.dmem_ack = 1'b1;
        tick();
        check("post_rst_wb", 64'(bus.wb_valid), 64'd0);
        bus.dmem_ack = 1'b0;
        tick();
        check("post_rst_wb2", 64'(bus.wb_valid), 64'd0);
        tick();
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
